// File: rtl/phys_free_list.sv
// Circular-FIFO free list of physical register tags with INIT fill and a single checkpoint/restore.
// Optional macro FREELIST_DUP_CHECK_EN adds an in-list bitmap and the err_double_free_o flag.
module phys_free_list #(
  parameter int PHYS_REGS = 128,
  parameter int ARCH_REGS = 32,
  parameter int TAG_W     = $clog2(PHYS_REGS),
  parameter int DEPTH     = PHYS_REGS - ARCH_REGS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_req_i,
  output logic             alloc_grant_o,
  output logic [TAG_W-1:0] alloc_tag_o,
  input  logic             rel_valid_i,
  input  logic [TAG_W-1:0] rel_tag_i,
  input  logic             ckpt_save_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic [TAG_W-1:0] free_count_o,
  output logic             empty_o,
  output logic             err_overflow_o,
`ifdef FREELIST_DUP_CHECK_EN
  output logic             err_double_free_o,
`endif
  output logic             state_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] init_cnt_q, init_cnt_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, snap_head_q, snap_head_d;
  logic [TAG_W-1:0] count_q, count_d, snap_count_q, snap_count_d;
  logic [TAG_W-1:0] rel_since_q, rel_since_d;
  logic             err_ovf_q, err_ovf_d;
  logic [TAG_W-1:0] mem_q [DEPTH];

  logic             run, full, dup_hit, rel_try, rel_ok;
  logic [PTR_W-1:0] head_upd;
  logic [TAG_W-1:0] count_upd, rel_since_upd, restore_cnt;
  logic [TAG_W:0]   restore_sum;
  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  logic [TAG_W-1:0] mem_wdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake: a tag is consumed only when alloc_grant_o is high at the rising edge;
  // alloc_tag_o is meaningful only in that cycle. Releases are fire-and-forget.
  assign run           = (state_q == S_RUN);
  assign full          = (count_q == TAG_W'(DEPTH));
  assign empty_o       = (count_q == '0);
  assign alloc_grant_o = alloc_req_i & run & ~empty_o & ~flush_i;
  assign alloc_tag_o   = mem_q[head_q];
  assign ready_o       = run;
  assign free_count_o  = count_q;
  assign err_overflow_o = err_ovf_q;
  assign state_o       = state_q;

  assign rel_try   = run & rel_valid_i;
  assign rel_ok    = rel_try & ~full & ~dup_hit;
  assign head_upd  = alloc_grant_o ? ptr_inc(head_q) : head_q;
  assign count_upd = count_q + TAG_W'(rel_ok) - TAG_W'(alloc_grant_o);
  assign rel_since_upd = (rel_ok && rel_since_q != TAG_W'(DEPTH)) ? rel_since_q + 1'b1 : rel_since_q;
  // Restored count can exceed the physical capacity if released tags overlapped the rewound region.
  assign restore_sum = {1'b0, snap_count_q} + {1'b0, rel_since_upd};
  assign restore_cnt = (restore_sum > (TAG_W+1)'(DEPTH)) ? TAG_W'(DEPTH) : restore_sum[TAG_W-1:0];

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    snap_head_d = snap_head_q;
    snap_count_d = snap_count_q;
    rel_since_d = rel_since_q;
    err_ovf_d   = err_ovf_q;
    mem_we      = 1'b0;
    mem_waddr   = tail_q;
    mem_wdata   = rel_tag_i;
    case (state_q)
      S_INIT: begin
        mem_we     = 1'b1;
        mem_waddr  = init_cnt_q;
        mem_wdata  = TAG_W'(ARCH_REGS) + TAG_W'(init_cnt_q);
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == PTR_W'(DEPTH - 1)) begin
          init_cnt_d = '0;
          tail_d     = '0;
          count_d    = TAG_W'(DEPTH);
          state_d    = S_RUN;
        end
      end
      default: begin
        if (rel_ok) begin
          mem_we = 1'b1;
          tail_d = ptr_inc(tail_q);
        end
        if (rel_try && full) err_ovf_d = 1'b1;
        if (flush_i) begin
          head_d      = snap_head_q;
          count_d     = restore_cnt;
          rel_since_d = rel_since_upd;
        end else begin
          head_d  = head_upd;
          count_d = count_upd;
          if (ckpt_save_i) begin
            snap_head_d  = head_upd;
            snap_count_d = count_upd;
            rel_since_d  = '0;
          end else begin
            rel_since_d = rel_since_upd;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      init_cnt_q   <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      snap_head_q  <= '0;
      snap_count_q <= '0;
      rel_since_q  <= '0;
      err_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      snap_head_q  <= snap_head_d;
      snap_count_q <= snap_count_d;
      rel_since_q  <= rel_since_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

`ifdef FREELIST_DUP_CHECK_EN
  logic [PHYS_REGS-1:0] in_list_q, in_list_d, snap_list_q, snap_list_d;
  logic                 err_dbl_q, err_dbl_d;

  // Tag 0 is the hard-wired x0 mapping and must never enter the list.
  assign dup_hit           = in_list_q[rel_tag_i] | (rel_tag_i == '0);
  assign err_double_free_o = err_dbl_q;

  always_comb begin
    in_list_d   = in_list_q;
    snap_list_d = snap_list_q;
    err_dbl_d   = err_dbl_q;
    if (state_q == S_INIT) begin
      in_list_d[TAG_W'(ARCH_REGS) + TAG_W'(init_cnt_q)] = 1'b1;
    end else begin
      if (rel_try && dup_hit) err_dbl_d = 1'b1;
      if (alloc_grant_o) in_list_d[alloc_tag_o] = 1'b0;
      if (rel_ok) begin
        in_list_d[rel_tag_i]   = 1'b1;
        snap_list_d[rel_tag_i] = 1'b1;
      end
      if (flush_i) in_list_d = snap_list_d;
      else if (ckpt_save_i) snap_list_d = in_list_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_list_q   <= '0;
      snap_list_q <= '0;
      err_dbl_q   <= 1'b0;
    end else begin
      in_list_q   <= in_list_d;
      snap_list_q <= snap_list_d;
      err_dbl_q   <= err_dbl_d;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// Directed bench for phys_free_list: INIT fill, drain, release, overflow, checkpoint/flush, reset.
module tb_phys_free_list;

  localparam int TAG_W = 7;
  localparam int DEPTH = 96;

  logic             clk, rst_n;
  logic             alloc_req, alloc_grant, rel_valid, ckpt_save, flush;
  logic [TAG_W-1:0] alloc_tag, rel_tag, free_count;
  logic             ready, empty, err_overflow, state;
`ifdef FREELIST_DUP_CHECK_EN
  logic             err_double_free;
`endif

  phys_free_list dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alloc_req_i      (alloc_req),
    .alloc_grant_o    (alloc_grant),
    .alloc_tag_o      (alloc_tag),
    .rel_valid_i      (rel_valid),
    .rel_tag_i        (rel_tag),
    .ckpt_save_i      (ckpt_save),
    .flush_i          (flush),
    .ready_o          (ready),
    .free_count_o     (free_count),
    .empty_o          (empty),
    .err_overflow_o   (err_overflow),
`ifdef FREELIST_DUP_CHECK_EN
    .err_double_free_o(err_double_free),
`endif
    .state_o          (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             alloc;
    logic             rel;
    logic [TAG_W-1:0] tag;
    logic             save;
    logic             flush;
    logic             exp_grant;
    logic [TAG_W-1:0] exp_tag;
    int               exp_count;
  } vec_t;

  vec_t             tbl [17];
  logic [TAG_W-1:0] exp_q [$];
  int               checks = 0;
  int               failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic a, input logic r, input int t, input logic s,
                              input logic f, input logic g, input int et, input int ec);
    vec_t v;
    v.alloc = a; v.rel = r; v.tag = TAG_W'(t); v.save = s; v.flush = f;
    v.exp_grant = g; v.exp_tag = TAG_W'(et); v.exp_count = ec;
    return v;
  endfunction

  // driver: called just after a falling edge
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      alloc_req = tbl[i].alloc; rel_valid = tbl[i].rel; rel_tag = tbl[i].tag;
      ckpt_save = tbl[i].save;  flush = tbl[i].flush;
      #1;
      chk($sformatf("vec%0d_grant", i), int'(alloc_grant), int'(tbl[i].exp_grant));
      if (tbl[i].exp_grant) chk($sformatf("vec%0d_tag", i), int'(alloc_tag), int'(tbl[i].exp_tag));
      next_cycle();
      chk($sformatf("vec%0d_count", i), int'(free_count), tbl[i].exp_count);
    end
    alloc_req = 1'b0; rel_valid = 1'b0; ckpt_save = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; alloc_req = 1'b1; rel_valid = 1'b0; rel_tag = '0;
    ckpt_save = 1'b0; flush = 1'b0;

    // release 5 then 7 into an empty list
    tbl[0]  = mk(1, 1, 5, 0, 0, 0, 0, 1);
    tbl[1]  = mk(1, 1, 7, 0, 0, 1, 5, 1);
    tbl[2]  = mk(1, 0, 0, 0, 0, 1, 7, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    // release into a full list
    tbl[4]  = mk(0, 1, 9, 0, 0, 0, 0, 96);
    // checkpoint at 90, 3 allocs, 1 release, flush, replay
    tbl[5]  = mk(0, 0, 0, 1, 0, 0, 0, 90);
    tbl[6]  = mk(1, 0, 0, 0, 0, 1, 38, 89);
    tbl[7]  = mk(1, 0, 0, 0, 0, 1, 39, 88);
    tbl[8]  = mk(1, 0, 0, 0, 0, 1, 40, 87);
    tbl[9]  = mk(0, 1, 3, 0, 0, 0, 0, 88);
    tbl[10] = mk(1, 0, 0, 0, 1, 0, 0, 91);
    tbl[11] = mk(1, 0, 0, 0, 0, 1, 38, 90);
    tbl[12] = mk(1, 0, 0, 0, 0, 1, 39, 89);
    tbl[13] = mk(0, 0, 0, 1, 1, 0, 0, 91);
    tbl[14] = mk(1, 0, 0, 0, 0, 1, 38, 90);
    tbl[15] = mk(0, 0, 0, 0, 1, 0, 0, 91);
    tbl[16] = mk(1, 0, 0, 0, 0, 1, 38, 90);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", int'(ready), 0);
    chk("rst_count", int'(free_count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_err_ovf", int'(err_overflow), 0);
    chk("rst_grant", int'(alloc_grant), 0);
    chk("rst_state", int'(state), 0);

    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("init%0d_ready", i), int'(ready), 0);
      chk($sformatf("init%0d_grant", i), int'(alloc_grant), 0);
      next_cycle();
    end
    chk("run_ready", int'(ready), 1);
    chk("run_count", int'(free_count), DEPTH);
    chk("run_tag", int'(alloc_tag), 32);

    // drain: scoreboard of expected allocation order
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(TAG_W'(32 + i));
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain%0d_grant", i), int'(alloc_grant), 1);
      if (alloc_grant && exp_q.size() > 0)
        chk($sformatf("drain%0d_tag", i), int'(alloc_tag), int'(exp_q.pop_front()));
      next_cycle();
    end
    chk("drain_empty", int'(empty), 1);
    chk("drain_count", int'(free_count), 0);
    chk("drain_grant97", int'(alloc_grant), 0);

    apply_range(0, 3);

    for (int i = 0; i < DEPTH; i++) begin
      rel_valid = 1'b1; rel_tag = TAG_W'(32 + i);
      next_cycle();
    end
    rel_valid = 1'b0;
    chk("fill_count", int'(free_count), DEPTH);
    chk("fill_err_ovf", int'(err_overflow), 0);
    chk("fill_tag", int'(alloc_tag), 32);

    apply_range(4, 4);
    chk("ovf_flag", int'(err_overflow), 1);

    alloc_req = 1'b1;
    repeat (6) next_cycle();
    alloc_req = 1'b0;
    chk("pre_ckpt_count", int'(free_count), 90);
    chk("pre_ckpt_tag", int'(alloc_tag), 38);

    apply_range(5, 16);

`ifdef FREELIST_DUP_CHECK_EN
    rel_valid = 1'b1; rel_tag = TAG_W'(40);
    next_cycle();
    rel_valid = 1'b0;
    chk("dup_flag", int'(err_double_free), 1);
    chk("dup_count", int'(free_count), 90);
`endif

    next_cycle();
    chk("ovf_sticky", int'(err_overflow), 1);

    // asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", int'(ready), 0);
    chk("midrst_count", int'(free_count), 0);
    chk("midrst_err_ovf", int'(err_overflow), 0);
    chk("midrst_state", int'(state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) next_cycle();
    chk("refill_ready", int'(ready), 0);
    repeat (DEPTH - 10) next_cycle();
    chk("refill_done", int'(ready), 1);
    chk("refill_tag", int'(alloc_tag), 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phys_free_list.md
Name: phys_free_list

Overview:
- Circular-FIFO free list of physical register tags for the rename stage.
- Supplies a fresh destination tag to the register alias table on each rename of an Rd-writing instruction.
- Accepts tags back when they are freed: either the previous mapping of Rd, or the tag of a non-writing instruction at commit.
- After reset, an INIT sequencer fills the FIFO with tags ARCH_REGS..PHYS_REGS-1. Single checkpoint/restore supports branch-mispredict recovery.

Parameters:
- PHYS_REGS, 128, number of physical registers.
- ARCH_REGS, 32, number of architectural registers, identity-mapped at reset.
- TAG_W, 7, physical tag width, equal to clog2(PHYS_REGS).
- DEPTH, PHYS_REGS-ARCH_REGS (96), FIFO entries; need not be a power of 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- alloc_req  in  1  rename stage requests one tag this cycle.
- alloc_grant  out  1  combinational; equals alloc_req & ready & ~empty & ~flush.
- alloc_tag  out  TAG_W  tag at head; valid when alloc_grant=1.
- rel_valid  in  1  release one tag this cycle.
- rel_tag  in  TAG_W  tag being released.
- ckpt_save  in  1  snapshot head pointer and count.
- flush  in  1  restore head and count from the snapshot.
- ready  out  1  0 during INIT, 1 in RUN.
- free_count  out  TAG_W  number of tags in the FIFO, 0..DEPTH.
- empty  out  1  free_count==0.
- err_overflow  out  1  sticky; a release was attempted while the FIFO was full.

Behaviour:
- Reset values:
  - State INIT; head=0, tail=0, init_cnt=0, free_count=0.
  - ready=0, err_overflow=0; snapshot head/count = 0.
  - Memory contents are undefined.
- INIT state:
  - Each cycle: mem[init_cnt] <= ARCH_REGS+init_cnt, init_cnt++.
  - After DEPTH writes: tail=0 (wrapped), free_count=DEPTH, state to RUN. ready=1 from the next cycle.
  - init takes exactly DEPTH cycles after reset deassertion.
  - alloc_req, rel_valid, ckpt_save and flush are ignored in INIT; alloc_grant=0.
- RUN, allocate:
  - If alloc_grant=1, head advances by 1 at the clock edge.
  - Pointer wrap: DEPTH-1 goes to 0.
- RUN, release:
  - If rel_valid=1 and free_count<DEPTH: mem[tail] <= rel_tag, tail advances with wrap.
  - If rel_valid=1 and free_count==DEPTH: write dropped, err_overflow <= 1.
- free_count next = free_count + release accepted - alloc granted.
  - Simultaneous alloc and release keeps count unchanged.
  - When empty, a same-cycle release is NOT bypassed to alloc_tag. alloc_grant=0 that cycle; the tag is visible next cycle.
- Checkpoint:
  - ckpt_save samples the post-update head, and the post-update count minus releases since the snapshot. Implementation: snap_head <= head_next; rel_since <= 0.
  - rel_since counts accepted releases after the snapshot.
- Flush:
  - head <= snap_head.
  - free_count <= snap_count_base + rel_since, where snap_count_base = free_count_next at save.
  - alloc_grant is forced 0 during the flush cycle.
  - A release in the flush cycle is still accepted and included in rel_since.
  - ckpt_save and flush in the same cycle: flush wins, save ignored.
- reset asserted mid-operation returns to INIT immediately (asynchronous) and restarts the fill.

Optional Feature:
- Macro FREELIST_DUP_CHECK_EN.
- When defined:
  - Adds a PHYS_REGS-bit in_list bitmap, built during INIT and updated on alloc/release.
  - Flush marks restored entries using a snapshot of the bitmap.
  - Adds output err_double_free (sticky, reset 0). It is set when rel_tag is already in the list or rel_tag<1 (x0 tag 0); that release is dropped.
- When undefined: no bitmap, no port; every release is accepted subject only to the full check.

Test Plan:
- Release reset, hold alloc_req=1 → ready=0 and alloc_grant=0 for 96 cycles. Then ready=1, free_count=96, alloc_tag=32.
- 96 back-to-back allocs → tags 32..127 in order, then empty=1 and alloc_grant=0 on the 97th request.
- After draining, release tags 5,7 in successive cycles with alloc_req=1 → no grant in the release cycle of 5. Next cycles grant 5 then 7; head wraps 95→0 correctly.
- With the FIFO full (96), rel_valid=1 tag 9 → free_count stays 96, err_overflow=1 and stays 1 until reset.
- ckpt_save at free_count=96, then 3 allocs (32,33,34) and 1 release (tag 3), then flush → free_count=97 is impossible, so the bench caps at DEPTH. Use the start count 90 instead: flush yields count 91, next allocs return the original snapshot-head tags again.
- FREELIST_DUP_CHECK_EN: release tag 40 while 40 is still free → err_double_free=1, free_count unchanged.
